// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: a loader streams words in over a valid/ready port.
// Fetches have a registered 1-cycle latency and return NOP_VALUE with a fault flag.
module instruction_memory_loadable #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 6,
  parameter int unsigned            DEPTH      = 41,
  parameter logic [DATA_WIDTH-1:0]  NOP_VALUE  = DATA_WIDTH'(32'h2000_0000)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic                  load_overflow,
  output logic [ADDR_WIDTH:0]   loaded_count,
  output logic                  memory_ready,
  input  logic                  fetch_enable,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [DATA_WIDTH-1:0] instruction_data_output,
  output logic                  instruction_valid,
  output logic                  instruction_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic                  valid_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  fetch_fault;

  assign load_ready    = (state_q == S_LOAD) && (count_q < DEPTH_C);
  assign load_overflow = ovf_q;
  assign loaded_count  = count_q;
  assign memory_ready  = (state_q == S_RUN);

  assign instruction_valid       = valid_q;
  assign instruction_fault       = fault_q;
  assign instruction_data_output = data_q;

  // load_start takes priority over everything else in the same cycle, including
  // a concurrent load_valid or load_done.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (load_start) begin
      state_d = S_LOAD;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if ((state_q == S_LOAD) && load_valid) begin
        if (load_ready) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE_C;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (load_done && (state_q != S_RUN)) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset; only the word count gates reads.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      ram_q[count_q[ADDR_WIDTH-1:0]] <= load_data;
    end
  end

  assign fetch_fault = (state_q != S_RUN) || ({1'b0, instruction_address} >= count_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else begin
      valid_q <= fetch_enable;
      fault_q <= fetch_enable && fetch_fault;
      if (fetch_enable) begin
        data_q <= fetch_fault ? NOP_VALUE : ram_q[instruction_address];
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomized bench for instruction_memory_loadable: a behavioural model tracks
// the loaded program and is compared against the DUT on every falling edge.
module tb_instruction_memory_loadable;

  localparam int          DW    = 32;
  localparam int          AW    = 6;
  localparam int          DEPTH = 41;
  localparam logic [31:0] NOP   = 32'h2000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ls = 1'b0, lv = 1'b0, ld = 1'b0, fe = 1'b0;
  logic [DW-1:0] ldata = '0;
  logic [AW-1:0] addr = '0;
  logic          ready, ovf, mready, ivalid, ifault;
  logic [AW:0]   cnt;
  logic [DW-1:0] idata;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b1;

  instruction_memory_loadable #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .NOP_VALUE  (NOP)
  ) dut (
    .clock                   (clk),
    .reset_n                 (rst_n),
    .load_start              (ls),
    .load_valid              (lv),
    .load_data               (ldata),
    .load_ready              (ready),
    .load_done               (ld),
    .load_overflow           (ovf),
    .loaded_count            (cnt),
    .memory_ready            (mready),
    .fetch_enable            (fe),
    .instruction_address     (addr),
    .instruction_data_output (idata),
    .instruction_valid       (ivalid),
    .instruction_fault       (ifault)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=idle, 1=loading, 2=running
  int          m_mode;
  int          m_count;
  bit          m_ovf, m_valid, m_fault;
  logic [31:0] m_data;
  logic [31:0] mem [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_ovf = 0;
      m_valid = 0; m_fault = 0; m_data = NOP;
    end else begin
      if (fe) begin
        m_valid = 1;
        if (m_mode != 2 || int'(addr) >= m_count) begin
          m_fault = 1; m_data = NOP;
        end else begin
          m_fault = 0; m_data = mem[addr];
        end
      end else begin
        m_valid = 0; m_fault = 0;
      end
      if (ls) begin
        m_mode = 1; m_count = 0; m_ovf = 0;
      end else begin
        if (m_mode == 1 && lv) begin
          if (m_count < DEPTH) begin
            mem[m_count] = ldata;
            m_count++;
          end else begin
            m_ovf = 1;
          end
        end
        if (ld && m_mode != 2) m_mode = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("valid", 64'(ivalid), 64'(m_valid));
      chk("fault", 64'(ifault), 64'(m_fault));
      chk("data", 64'(idata), 64'(m_data));
      chk("count", 64'(cnt), 64'(m_count));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("load_ready", 64'(ready), 64'(m_mode == 1 && m_count < DEPTH));
      chk("memory_ready", 64'(mready), 64'(m_mode == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    ls = 0; lv = 0; ld = 0; fe = 0;
  endtask

  initial begin
    idle_in();
    repeat (3) @(posedge clk);
    #2;
    chk("reset count", 64'(cnt), 64'd0);
    chk("reset data", 64'(idata), 64'(NOP));
    chk("reset valid", 64'(ivalid), 64'd0);
    rst_n = 1;
    tick();

    // Three-word program, back-to-back fetches
    ls = 1; tick(); ls = 0;
    lv = 1; ldata = 32'h1111_1111; tick();
    ldata = 32'h2222_2222; tick();
    ldata = 32'h3333_3333; tick();
    lv = 0; ld = 1; tick(); ld = 0;
    chk("t1 count", 64'(cnt), 64'd3);
    chk("t1 memory_ready", 64'(mready), 64'd1);
    fe = 1; addr = 0; tick();
    chk("t1 data0", 64'(idata), 64'h1111_1111);
    addr = 1; tick();
    chk("t1 data1", 64'(idata), 64'h2222_2222);
    addr = 2; tick();
    chk("t1 data2", 64'(idata), 64'h3333_3333);
    chk("t1 fault", 64'(ifault), 64'd0);

    // Out-of-program fetches
    addr = 3; tick();
    chk("t2 data3", 64'(idata), 64'(NOP));
    chk("t2 fault3", 64'(ifault), 64'd1);
    addr = 63; tick();
    chk("t2 fault63", 64'(ifault), 64'd1);
    chk("t2 valid63", 64'(ivalid), 64'd1);
    fe = 0; tick();
    chk("t2 hold data", 64'(idata), 64'(NOP));

    // load_valid while running is ignored
    lv = 1; ldata = 32'hDEAD_BEEF; tick(); lv = 0;
    chk("t4 run count", 64'(cnt), 64'd3);

    // Fill the memory, then offer one word too many; fetch during LOAD faults
    ls = 1; tick(); ls = 0;
    for (int i = 0; i < DEPTH; i++) begin
      lv = 1; ldata = 32'hC0DE_0000 | 32'(i);
      fe = (i == 5); addr = 0;
      tick();
      if (i == 5) chk("t4 load fetch fault", 64'(ifault), 64'd1);
    end
    fe = 0;
    ldata = 32'hBAD0_BAD0;
    chk("t3 ready full", 64'(ready), 64'd0);
    tick(); lv = 0;
    chk("t3 overflow", 64'(ovf), 64'd1);
    chk("t3 count", 64'(cnt), 64'd41);
    ld = 1; tick(); ld = 0;
    fe = 1; addr = 40; tick();
    chk("t3 data40", 64'(idata), 64'hC0DE_0028);
    chk("t3 fault40", 64'(ifault), 64'd0);

    // Fetch concurrent with load_start is served from RUN
    addr = 0; ls = 1; tick(); fe = 0;
    chk("t6 fetch at start", 64'(idata), 64'hC0DE_0000);
    chk("t6 fault at start", 64'(ifault), 64'd0);
    chk("t6 ovf cleared", 64'(ovf), 64'd0);
    ls = 1; ld = 1; tick(); ls = 0; ld = 0;
    chk("t6 start+done mready", 64'(mready), 64'd0);
    chk("t6 start+done count", 64'(cnt), 64'd0);
    chk("t6 start+done ready", 64'(ready), 64'd1);

    // Asynchronous reset mid-load after two words
    lv = 1; fe = 1; addr = 0; ldata = 32'hAAAA_0001; tick();
    ldata = 32'hAAAA_0002; tick();
    chk("t5 count pre", 64'(cnt), 64'd2);
    chk("t5 valid pre", 64'(ivalid), 64'd1);
    rst_n = 0; #1;
    chk("t5 count", 64'(cnt), 64'd0);
    chk("t5 valid", 64'(ivalid), 64'd0);
    chk("t5 fault", 64'(ifault), 64'd0);
    chk("t5 data", 64'(idata), 64'(NOP));
    chk("t5 ready", 64'(ready), 64'd0);
    idle_in(); tick(); rst_n = 1; tick();

    // Fetch in IDLE, then load_done from IDLE gives an empty program
    fe = 1; addr = 0; tick(); fe = 0;
    chk("t4 idle fault", 64'(ifault), 64'd1);
    ld = 1; tick(); ld = 0;
    chk("t6 idle done mready", 64'(mready), 64'd1);
    fe = 1; addr = 0; tick(); fe = 0;
    chk("t6 empty fault", 64'(ifault), 64'd1);
    chk("t6 empty data", 64'(idata), 64'(NOP));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ls    = ($urandom_range(0, 99) == 0);
      ld    = ($urandom_range(0, 59) == 0);
      lv    = $urandom_range(0, 1);
      fe    = $urandom_range(0, 1);
      addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 42));
      ldata = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0; tick(); rst_n = 1;
      end else begin
        tick();
      end
    end
    idle_in();
    tick();
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
